// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Purpose  : Up-counter over 1..rollover_val with a registered rollover flag.
// Revision : 1.0 - initial release
// ============================================================================
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] C_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] C_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] next_count;

  // Rollover restarts at 1, so 0 only appears after clear, reset or a wrap.
  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = C_ZERO;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = C_ONE;
      end else begin
        next_count = count_out + C_ONE;
      end
    end
  end

  // Flag is derived from next_count so it aligns with count_out in the same cycle.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count_out     <= C_ZERO;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= (next_count == rollover_val);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flex_counter.sv
`default_nettype none
// Testbench for flex_counter: directed vector table, hand sequences, then
// randomized stimulus against an arithmetic reference model.
module tb_flex_counter;

  localparam int NUM_CNT_BITS = 4;
  localparam int MODULUS      = 1 << NUM_CNT_BITS;

  logic                    clk;
  logic                    n_rst;
  logic                    clear;
  logic                    count_enable;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       rst;
    bit       clr;
    bit       en;
    bit [3:0] rv;
    bit [3:0] exp_cnt;
    bit       exp_flg;
  } vec_t;

  vec_t vq[$];

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(bit rst, bit clr, bit en, int rv, int ec, bit ef);
    vec_t v;
    v.rst = rst; v.clr = clr; v.en = en;
    v.rv = rv[3:0]; v.exp_cnt = ec[3:0]; v.exp_flg = ef;
    vq.push_back(v);
  endfunction

  task automatic step(input bit rst, input bit clr, input bit en, input logic [3:0] rv);
    n_rst = rst; clear = clr; count_enable = en; rollover_val = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int act_cnt,
                       input int act_flg, input int exp_cnt, input int exp_flg);
    checks++;
    if (act_cnt != exp_cnt) begin
      errors++;
      $display("FAIL %s[%0d] count_out actual=%0d required=%0d", name, idx, act_cnt, exp_cnt);
    end
    checks++;
    if (act_flg != exp_flg) begin
      errors++;
      $display("FAIL %s[%0d] rollover_flag actual=%0d required=%0d", name, idx, act_flg, exp_flg);
    end
  endtask

  initial begin
    int mdl_cnt;
    bit mdl_flg;
    bit r_rst, r_clr, r_en;
    int r_rv;

    n_rst = 1'b1; clear = 1'b0; count_enable = 1'b0; rollover_val = 4'd15;

    // Directed scenarios (each row is one edge from the previous row's state).
    add(1, 0, 1, 15, 0, 0);                 // reset wins over enable
    add(0, 1, 1,  2, 0, 0);                 // clear wins over enable
    add(0, 0, 1, 15, 1, 0);
    add(0, 1, 0,  2, 0, 0);                 // back to 0
    add(0, 0, 1,  2, 1, 0);
    add(0, 0, 1,  2, 2, 1);
    add(0, 0, 1,  2, 1, 0);                 // rollover skips 0
    add(0, 0, 0,  2, 1, 0);
    add(0, 0, 0,  2, 1, 0);
    add(0, 1, 0,  2, 0, 0);
    for (int i = 1; i <= 13; i++) add(0, 0, 1, 14, i, 0);
    add(0, 0, 1, 14, 14, 1);
    add(0, 0, 1, 14, 1, 0);
    add(0, 0, 1, 14, 2, 0);
    add(1, 1, 0,  1, 0, 0);                 // reset mid-count
    add(0, 0, 1,  1, 1, 1);                 // resume from 0
    add(0, 0, 0,  1, 1, 1);                 // hold at rollover keeps flag
    add(0, 1, 0,  0, 0, 1);                 // rollover_val 0: clear sets flag
    add(0, 0, 1,  0, 1, 0);
    add(0, 0, 1, 15, 2, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].clr, vq[i].en, vq[i].rv);
      check("table", i, int'(count_out), int'(rollover_flag),
            int'(vq[i].exp_cnt), int'(vq[i].exp_flg));
    end

    // Lowered rollover below the current count: climb, wrap through 0, land on 1.
    step(0, 0, 1, 15);
    check("lowered", 0, int'(count_out), int'(rollover_flag), 3, 0);
    for (int c = 4; c <= 15; c++) begin
      step(0, 0, 1, 4'd1);
      check("lowered", c, int'(count_out), int'(rollover_flag), c, 0);
    end
    step(0, 0, 1, 4'd1);
    check("lowered_wrap", 0, int'(count_out), int'(rollover_flag), 0, 0);
    step(0, 0, 1, 4'd1);
    check("lowered_hit", 0, int'(count_out), int'(rollover_flag), 1, 1);

    // Wrap to 0 with rollover_val 0 sets the flag.
    step(0, 0, 1, 4'd15);
    for (int c = 3; c <= 15; c++) step(0, 0, 1, 4'd15);
    check("wrap_pre", 0, int'(count_out), int'(rollover_flag), 15, 1);
    step(0, 1, 0, 4'd5);
    step(0, 0, 1, 4'd0);
    check("wrap_pre2", 0, int'(count_out), int'(rollover_flag), 1, 0);
    for (int c = 2; c <= 15; c++) step(0, 0, 1, 4'd0);
    step(0, 0, 1, 4'd0);
    check("wrap_zero", 0, int'(count_out), int'(rollover_flag), 0, 1);

    // Randomized stimulus against the reference model.
    step(1, 0, 0, 4'd0);
    mdl_cnt = 0;
    mdl_flg = 0;
    r_rv = 7;
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(31) == 0);
      r_clr = ($urandom_range(15) == 0);
      r_en  = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) r_rv = $urandom_range(MODULUS - 1);
      if (r_rst) begin
        mdl_cnt = 0;
        mdl_flg = 0;
      end else begin
        if (r_clr) mdl_cnt = 0;
        else if (r_en) mdl_cnt = (mdl_cnt == r_rv) ? 1 : (mdl_cnt + 1) % MODULUS;
        mdl_flg = (mdl_cnt == r_rv);
      end
      step(r_rst, r_clr, r_en, r_rv[3:0]);
      check("random", i, int'(count_out), int'(rollover_flag), mdl_cnt, int'(mdl_flg));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
